// File: rtl/fb_pkg.sv
// fb_pkg: shared role/state types and address-width helper for multi_framebuffer
package fb_pkg;
  typedef enum logic [1:0] {FRONT, PENDING, BACK, FREE} fb_role_t;
  typedef enum logic [1:0] {WRITING, ACQUIRE, WAIT_BUF, CLEARING} fb_wr_state_t;
  function automatic int fb_addr_w(input int width, input int height);
    return (width * height > 1) ? $clog2(width * height) : 1;
  endfunction
endpackage

// File: rtl/fb_bank.sv
// fb_bank: single-clock simple dual-port RAM with registered read port
module fb_bank #(
  parameter int DW    = 12,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/multi_framebuffer.sv
// multi_framebuffer: N-way mailbox framebuffer with tear-free promotion at frame_start
// and a clear engine that fills each newly acquired back buffer.
module multi_framebuffer
  import fb_pkg::*;
#(
  parameter int FB_WIDTH     = 160,
  parameter int FB_HEIGHT    = 120,
  parameter int NUM_BUFFERS  = 3,
  parameter int PIXEL_WIDTH  = 12,
  parameter int CLEAR_ENABLE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           write_enable,
  input  logic [$clog2(FB_WIDTH)-1:0]    write_x,
  input  logic [$clog2(FB_HEIGHT)-1:0]   write_y,
  input  logic [PIXEL_WIDTH-1:0]         write_data,
  output logic                           write_ready,
  input  logic                           swap,
  input  logic [PIXEL_WIDTH-1:0]         clear_color,
  input  logic                           frame_start,
  input  logic [$clog2(FB_WIDTH)-1:0]    read_x,
  input  logic [$clog2(FB_HEIGHT)-1:0]   read_y,
  output logic [PIXEL_WIDTH-1:0]         read_data,
  output logic [$clog2(NUM_BUFFERS)-1:0] front_index,
  output logic                           frame_dropped
);
  localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int AW    = fb_addr_w(FB_WIDTH, FB_HEIGHT);
  localparam int IW    = $clog2(NUM_BUFFERS);
  fb_role_t                 role [NUM_BUFFERS];
  fb_wr_state_t             state;
  logic [IW-1:0]            back_idx, free_idx, pend_idx, rsel_q;
  logic                     free_found, pend_found, do_swap, clearing, wr_ok, bank_we, rd_ok, rvalid_q;
  logic [AW-1:0]            clr_cnt, waddr, raddr;
  logic [PIXEL_WIDTH-1:0]   clr_val, wdata;
  logic [PIXEL_WIDTH-1:0]   dout [NUM_BUFFERS];
  assign do_swap  = swap && write_ready;
  assign clearing = state == CLEARING;
  assign wr_ok    = write_enable && write_ready && int'(write_x) < FB_WIDTH && int'(write_y) < FB_HEIGHT;
  assign bank_we  = clearing || wr_ok;
  assign waddr    = clearing ? clr_cnt : AW'(int'(write_y) * FB_WIDTH + int'(write_x));
  assign wdata    = clearing ? clr_val : write_data;
  assign rd_ok    = int'(read_x) < FB_WIDTH && int'(read_y) < FB_HEIGHT;
  assign raddr    = rd_ok ? AW'(int'(read_y) * FB_WIDTH + int'(read_x)) : '0;
  // Descending scan so the lowest-index match wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (role[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (role[i] == PENDING) begin
        pend_found = 1'b1;
        pend_idx   = IW'(i);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BUFFERS; i++) role[i] <= (i == 0) ? FRONT : (i == 1) ? BACK : FREE;
      state         <= (CLEAR_ENABLE != 0) ? CLEARING : WRITING;
      write_ready   <= CLEAR_ENABLE == 0;
      back_idx      <= IW'(1);
      front_index   <= '0;
      clr_cnt       <= '0;
      clr_val       <= clear_color;
      frame_dropped <= 1'b0;
    end else begin
      frame_dropped <= do_swap && pend_found;
      if (do_swap && frame_start) begin
        for (int i = 0; i < NUM_BUFFERS; i++) if (role[i] == FRONT || role[i] == PENDING) role[i] <= FREE;
        role[back_idx] <= FRONT;
        front_index    <= back_idx;
      end else if (do_swap) begin
        if (pend_found) role[pend_idx] <= FREE;
        role[back_idx] <= PENDING;
      end else if (frame_start && pend_found) begin
        role[front_index] <= FREE;
        role[pend_idx]    <= FRONT;
        front_index       <= pend_idx;
      end
      case (state)
        WRITING: if (do_swap) begin
          state       <= ACQUIRE;
          write_ready <= 1'b0;
        end
        ACQUIRE: if (free_found) begin
          role[free_idx] <= BACK;
          back_idx       <= free_idx;
          clr_cnt        <= '0;
          clr_val        <= clear_color;
          state          <= (CLEAR_ENABLE != 0) ? CLEARING : WRITING;
          write_ready    <= CLEAR_ENABLE == 0;
        end else state <= WAIT_BUF;
        // A promotion this cycle frees the old front, so re-acquire without an idle cycle.
        WAIT_BUF: if (free_found || (frame_start && pend_found)) state <= ACQUIRE;
        CLEARING: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state       <= WRITING;
            write_ready <= 1'b1;
          end
        end
        default: state <= WRITING;
      endcase
    end
  end
  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_bank
    fb_bank #(.DW(PIXEL_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk  (clk),
      .we   (bank_we && back_idx == IW'(g)),
      .waddr(waddr),
      .wdata(wdata),
      .raddr(raddr),
      .rdata(dout[g])
    );
  end
  // Buffer select rides alongside the address so a pixel never mixes buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsel_q    <= '0;
      rvalid_q  <= 1'b0;
      read_data <= '0;
    end else begin
      rsel_q    <= front_index;
      rvalid_q  <= rd_ok;
      read_data <= rvalid_q ? dout[rsel_q] : '0;
    end
  end
endmodule
